// File: rtl/syn_fifo_v2_nb.sv
// Synchronous FIFO with simultaneous read/write, occupancy count, almost-full/empty thresholds
// and registered read data. Optional sticky error flags are built when SYN_FIFO_ERR_FLAGS_EN is defined.
module syn_fifo_v2_nb #(
    parameter int BUS_WIDTH     = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    input  logic [BUS_WIDTH-1:0]           DATA_IN,
    input  logic                           WR_EN,
    input  logic                           RD_EN,
    output logic [BUS_WIDTH-1:0]           DATA_OUT,
    output logic                           DATA_VALID,
    output logic                           FULL,
    output logic                           EMPTY,
    output logic                           ALMOST_FULL,
    output logic                           ALMOST_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]    COUNT,
    output logic                           OVERFLOW,
    output logic                           UNDERFLOW
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW:0]   AFULL_C  = (CW+1)'(AFULL_THRESH);
    localparam logic [CW:0]   AEMPTY_C = (CW+1)'(AEMPTY_THRESH);
    localparam logic [CW-1:0] LAST_PTR = CW'(FIFO_DEPTH - 1);

    logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0]        wr_ptr;
    logic [CW-1:0]        rd_ptr;
    logic [CW:0]          count;
    logic                 rd_acc;
    logic                 wr_acc;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = RD_EN && (count != '0);
    assign wr_acc = WR_EN && ((count != DEPTH_C) || rd_acc);

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= rd_acc;
            if (rd_acc) begin
                DATA_OUT <= mem[rd_ptr];
            end
        end
    end

    assign COUNT        = count;
    assign FULL         = (count == DEPTH_C);
    assign EMPTY        = (count == '0);
    assign ALMOST_FULL  = (count >= AFULL_C);
    assign ALMOST_EMPTY = (count <= AEMPTY_C);

`ifdef SYN_FIFO_ERR_FLAGS_EN
    // Sticky until reset; a rejected write or a read of an empty FIFO latches the error.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (WR_EN && !wr_acc) begin
                OVERFLOW <= 1'b1;
            end
            if (RD_EN && (count == '0)) begin
                UNDERFLOW <= 1'b1;
            end
        end
    end
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_syn_fifo_v2_nb.sv
// Randomised self-checking bench for syn_fifo_v2_nb: a depth-8 and a depth-6 instance checked
// against a queue-based reference model. Honours SYN_FIFO_ERR_FLAGS_EN for the error-flag expectations.
module tb_syn_fifo_v2_nb;

    logic       CLK;
    logic       RSTn;
    logic [7:0] data_in    [2];
    logic       wr_en      [2];
    logic       rd_en      [2];
    logic [7:0] data_out   [2];
    logic       data_valid [2];
    logic       full       [2];
    logic       empty      [2];
    logic       afull      [2];
    logic       aempty     [2];
    logic [3:0] count      [2];
    logic       ovf        [2];
    logic       unf        [2];

    // reference model state
    logic [7:0] mq [2][$];
    logic [7:0] m_dout  [2];
    logic       m_valid [2];
    logic       m_ovf   [2];
    logic       m_unf   [2];
    int         m_depth [2] = '{8, 6};
    int         m_af    [2] = '{6, 4};
    int         m_ae    [2] = '{2, 2};

    int n_checks = 0;
    int n_fail   = 0;

    syn_fifo_v2_nb #(.BUS_WIDTH(8), .FIFO_DEPTH(8)) dut8 (
        .CLK(CLK), .RSTn(RSTn), .DATA_IN(data_in[0]), .WR_EN(wr_en[0]), .RD_EN(rd_en[0]),
        .DATA_OUT(data_out[0]), .DATA_VALID(data_valid[0]), .FULL(full[0]), .EMPTY(empty[0]),
        .ALMOST_FULL(afull[0]), .ALMOST_EMPTY(aempty[0]), .COUNT(count[0]),
        .OVERFLOW(ovf[0]), .UNDERFLOW(unf[0])
    );

    syn_fifo_v2_nb #(.BUS_WIDTH(8), .FIFO_DEPTH(6), .AFULL_THRESH(4), .AEMPTY_THRESH(2)) dut6 (
        .CLK(CLK), .RSTn(RSTn), .DATA_IN(data_in[1]), .WR_EN(wr_en[1]), .RD_EN(rd_en[1]),
        .DATA_OUT(data_out[1]), .DATA_VALID(data_valid[1]), .FULL(full[1]), .EMPTY(empty[1]),
        .ALMOST_FULL(afull[1]), .ALMOST_EMPTY(aempty[1]), .COUNT(count[1]),
        .OVERFLOW(ovf[1]), .UNDERFLOW(unf[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {FULL, EMPTY, AF, AE, OVF, UNF, VALID, COUNT[3:0], DATA_OUT[7:0]}
    function automatic logic [18:0] obs_status(int u);
        return {full[u], empty[u], afull[u], aempty[u], ovf[u], unf[u], data_valid[u],
                count[u], data_out[u]};
    endfunction

    function automatic logic [18:0] exp_status(int u);
        int sz = mq[u].size();
        return {sz == m_depth[u], sz == 0, sz >= m_af[u], sz <= m_ae[u], m_ovf[u], m_unf[u],
                m_valid[u], 4'(sz), m_dout[u]};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            mq[u].delete();
            m_dout[u]  = 8'h00;
            m_valid[u] = 1'b0;
            m_ovf[u]   = 1'b0;
            m_unf[u]   = 1'b0;
        end
    endtask

    // One clock cycle on instance u; the model applies the acceptance rules from the pre-edge occupancy.
    task automatic drive(int u, logic wr, logic rd, logic [7:0] d);
        int  sz = mq[u].size();
        bit  ra = rd && (sz != 0);
        bit  wa = wr && ((sz != m_depth[u]) || ra);
        data_in[u] = d;
        wr_en[u]   = wr;
        rd_en[u]   = rd;
        @(posedge CLK);
        if (ra) m_dout[u] = mq[u].pop_front();
        m_valid[u] = ra;
        if (wa) mq[u].push_back(d);
`ifdef SYN_FIFO_ERR_FLAGS_EN
        if (wr && !wa) m_ovf[u] = 1'b1;
        if (rd && (sz == 0)) m_unf[u] = 1'b1;
`endif
        #1;
        wr_en[u] = 1'b0;
        rd_en[u] = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 RSTn = 1'b0;
        model_reset();
        #2 RSTn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (obs_status(u) !== {7'b0101000, 4'd0, 8'h00}) begin
                n_fail++;
                $display("[TB] FAIL reset_state u%0d: got %h want %h", u, obs_status(u),
                         {7'b0101000, 4'd0, 8'h00});
            end
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 1'b0, 8'h11 + 8'(i));
            n_checks++;
            if (obs_status(0) !== exp_status(0)) begin
                n_fail++;
                $display("[TB] FAIL fill step%0d: got %h want %h", i, obs_status(0), exp_status(0));
            end
        end
        n_checks++;
        if (full[0] !== 1'b1 || count[0] !== 4'd8) begin
            n_fail++;
            $display("[TB] FAIL fill_full: got full=%b count=%0d want full=1 count=8", full[0], count[0]);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (data_out[0] !== 8'h11 + 8'(i) || data_valid[0] !== 1'b1 ||
                obs_status(0) !== exp_status(0)) begin
                n_fail++;
                $display("[TB] FAIL drain step%0d: got %h want %h (data %h)", i, obs_status(0),
                         exp_status(0), 8'h11 + 8'(i));
            end
        end
        n_checks++;
        if (empty[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drain_empty: got %b want 1", empty[0]);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'b0, 8'h11 + 8'(i));
        drive(0, 1'b1, 1'b1, 8'hAA);
        n_checks++;
        if (data_out[0] !== 8'h11 || count[0] !== 4'd8 || full[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL full_simul: got dout=%h count=%0d full=%b want 11/8/1",
                     data_out[0], count[0], full[0]);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (obs_status(0) !== exp_status(0)) begin
                n_fail++;
                $display("[TB] FAIL full_simul_drain%0d: got %h want %h", i, obs_status(0), exp_status(0));
            end
        end
        n_checks++;
        if (data_out[0] !== 8'hAA) begin
            n_fail++;
            $display("[TB] FAIL full_simul_last: got %h want aa", data_out[0]);
        end
    endtask

    task automatic test_empty_simul();
        drive(0, 1'b1, 1'b1, 8'h5C);
        n_checks++;
        if (count[0] !== 4'd1 || data_valid[0] !== 1'b0 || obs_status(0) !== exp_status(0)) begin
            n_fail++;
            $display("[TB] FAIL empty_simul: got %h want %h", obs_status(0), exp_status(0));
        end
        drive(0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (data_out[0] !== 8'h5C || data_valid[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL empty_simul_read: got %h/%b want 5c/1", data_out[0], data_valid[0]);
        end
    endtask

    task automatic test_wrap_depth6();
        for (int i = 0; i < 3; i++) drive(1, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            drive(1, 1'b1, 1'b1, 8'($urandom));
            n_checks++;
            if (count[1] !== 4'd3 || obs_status(1) !== exp_status(1)) begin
                n_fail++;
                $display("[TB] FAIL wrap6 step%0d: got %h want %h", i, obs_status(1), exp_status(1));
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (obs_status(1) !== exp_status(1)) begin
                n_fail++;
                $display("[TB] FAIL wrap6_drain%0d: got %h want %h", i, obs_status(1), exp_status(1));
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 1'b0, 8'h01 + 8'(i));
        pulse_reset();
        n_checks++;
        if (obs_status(0) !== {7'b0101000, 4'd0, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL midreset_clear: got %h want %h", obs_status(0), {7'b0101000, 4'd0, 8'h00});
        end
        drive(0, 1'b1, 1'b0, 8'h77);
        drive(0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (data_out[0] !== 8'h77 || count[0] !== 4'd0 || empty[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_read: got dout=%h count=%0d empty=%b want 77/0/1",
                     data_out[0], count[0], empty[0]);
        end
    endtask

    task automatic test_error_flags();
        pulse_reset();
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'b0, 8'(i));
        drive(0, 1'b1, 1'b0, 8'h99);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_status(0) !== exp_status(0)) begin
                n_fail++;
                $display("[TB] FAIL overflow_hold%0d: got %h want %h", i, obs_status(0), exp_status(0));
            end
            drive(0, 1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < 9; i++) drive(0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (obs_status(0) !== exp_status(0)) begin
            n_fail++;
            $display("[TB] FAIL underflow: got %h want %h", obs_status(0), exp_status(0));
        end
`ifdef SYN_FIFO_ERR_FLAGS_EN
        n_checks++;
        if (ovf[0] !== 1'b1 || unf[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_sticky: got ovf=%b unf=%b want 1/1", ovf[0], unf[0]);
        end
`endif
        pulse_reset();
        n_checks++;
        if (ovf[0] !== 1'b0 || unf[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_clear: got ovf=%b unf=%b want 0/0", ovf[0], unf[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int u = int'($urandom_range(1, 0));
            drive(u, ($urandom_range(99, 0) < 55), ($urandom_range(99, 0) < 50), 8'($urandom));
            n_checks++;
            if (obs_status(u) !== exp_status(u)) begin
                n_fail++;
                $display("[TB] FAIL random u%0d step%0d: got %h want %h", u, i, obs_status(u), exp_status(u));
            end
        end
    endtask

    initial begin
        RSTn = 1'b0;
        for (int u = 0; u < 2; u++) begin
            data_in[u] = 8'h00;
            wr_en[u]   = 1'b0;
            rd_en[u]   = 1'b0;
        end
        model_reset();
        #12;
        test_reset();
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        test_fill_drain();
        test_full_simul();
        test_empty_simul();
        test_wrap_depth6();
        test_reset_midstream();
        test_error_flags();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
